bcd_to_bin_seq: RTL and testbench

BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

---
 rtl/bcd_pkg.sv | 11 +
 rtl/bcd_mac10.sv | 20 ++
 rtl/bcd_to_bin_seq.sv | 111 +++++++++++
 tb/tb_bcd_to_bin_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the sequential BCD-to-binary converter.
package bcd_pkg;
  localparam int BCD_W      = 4;
  localparam int BCD_MAX    = 9;
  localparam int DIGITS_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;
endpackage

// File: rtl/bcd_mac10.sv
// Combinational acc*10 + digit built from two shifts and adds, no multiplier.
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic [BIN_W-1:0] acc_in,
  input  logic [BCD_W-1:0] digit,
  output logic [BIN_W-1:0] acc_out
);
  logic [BIN_W-1:0] w_x8;
  logic [BIN_W-1:0] w_x2;
  logic [BIN_W-1:0] w_dig;

  assign w_x8    = acc_in << 3;
  assign w_x2    = acc_in << 1;
  assign w_dig   = BIN_W'(digit);
  // Carries past BIN_W are dropped, so overflow from invalid digits wraps.
  assign acc_out = w_x8 + w_x2 + w_dig;
endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first.
// Optional digit range check enabled by defining BCD_TO_BIN_CHECK_EN.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BCD_W*DIGITS-1:0] bcd_in,
  output logic                    busy,
  output logic                    done,
  output logic [BIN_W-1:0]        bin_out,
  output logic                    err
);
  localparam int               CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIGITS - 1);

  state_t                  r_state;
  logic [BCD_W*DIGITS-1:0] r_dig;
  logic [BIN_W-1:0]        r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_busy;
  logic                    r_done;
  logic [BIN_W-1:0]        r_bin;

  logic [BCD_W-1:0]        w_digit;
  logic [BIN_W-1:0]        w_acc_next;
  logic                    w_last;

  assign w_digit = r_dig[BCD_W*DIGITS-1 -: BCD_W];
  assign w_last  = (r_cnt == LAST);

  bcd_mac10 #(.BIN_W(BIN_W)) u_mac (
    .acc_in (r_acc),
    .digit  (w_digit),
    .acc_out(w_acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_dig   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bin   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // Accepted even while done is high, which gives back-to-back results.
          if (start) begin
            r_dig   <= bcd_in;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CONV;
          end
        end
        CONV: begin
          r_acc <= w_acc_next;
          r_dig <= r_dig << BCD_W;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_bin   <= w_acc_next;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign bin_out = r_bin;

`ifdef BCD_TO_BIN_CHECK_EN
  logic r_bad;
  logic r_err;
  logic w_bad_dig;

  assign w_bad_dig = (w_digit > BCD_W'(BCD_MAX));

  // Sticky over one conversion; only presented on err alongside done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bad <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_state == IDLE) begin
        if (start) r_bad <= 1'b0;
      end else begin
        r_bad <= r_bad | w_bad_dig;
        if (w_last) r_err <= r_bad | w_bad_dig;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: vector table, random values vs a
// positional-weight reference, held-start throughput, reset abort, DIGITS=2.
module tb_bcd_to_bin_seq;
  localparam int D   = 4;
  localparam int BW  = 14;
  localparam int D2  = 2;
  localparam int BW2 = 7;
`ifdef BCD_TO_BIN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   bcd_in = '0;
  logic          busy, done, err;
  logic [BW-1:0] bin_out;

  logic           start2 = 1'b0;
  logic [7:0]     bcd2 = '0;
  logic           busy2, done2, err2;
  logic [BW2-1:0] bin2;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.DIGITS(D), .BIN_W(BW)) dut (
    .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .bin_out(bin_out), .err(err)
  );

  bcd_to_bin_seq #(.DIGITS(D2), .BIN_W(BW2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bcd_in(bcd2),
    .busy(busy2), .done(done2), .bin_out(bin2), .err(err2)
  );

  typedef struct {
    logic [15:0] bcd;
    int unsigned bin;
    bit          bad;
  } vec_t;

  vec_t vecs[8];

  // Sum of digit * 10^position, then truncated to the output width.
  function automatic int unsigned ref_bin(logic [31:0] bcd, int nd, int bw);
    int unsigned s = 0;
    int unsigned p = 1;
    for (int i = 0; i < nd; i++) begin
      s = s + int'(bcd[4*i +: 4]) * p;
      p = p * 10;
    end
    return s % (32'd1 << bw);
  endfunction

  function automatic bit ref_bad(logic [31:0] bcd, int nd);
    bit b = 1'b0;
    for (int i = 0; i < nd; i++)
      if (bcd[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_conv(input string name, input logic [15:0] bcd,
                          input int unsigned exp_bin, input bit exp_err);
    int lat;
    int bcy;
    bcd_in = bcd;
    start  = 1'b1;
    step();
    start  = 1'b0;
    lat = 0;
    bcy = 0;
    while (!done && lat < 20) begin
      if (busy) bcy++;
      bcd_in = 16'($urandom);
      step();
      lat++;
    end
    check({name, " done"}, 32'(done), 32'd1);
    check({name, " latency"}, 32'(lat), 32'(D));
    check({name, " busy cycles"}, 32'(bcy), 32'(D));
    check({name, " busy at done"}, 32'(busy), 32'd0);
    check({name, " bin"}, 32'(bin_out), exp_bin);
    check({name, " err"}, 32'(err), 32'(exp_err & CHK));
    step();
    check({name, " done pulse"}, 32'(done), 32'd0);
    check({name, " err idle"}, 32'(err), 32'd0);
    check({name, " bin held"}, 32'(bin_out), exp_bin);
  endtask

  task automatic run2(input logic [7:0] bcd, input int unsigned exp_bin);
    int lat;
    bcd2   = bcd;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    bcd2   = 8'($urandom);
    lat = 0;
    while (!done2 && lat < 20) begin
      step();
      lat++;
    end
    check("d2 done", 32'(done2), 32'd1);
    check("d2 latency", 32'(lat), 32'(D2));
    check("d2 bin", 32'(bin2), exp_bin);
    step();
  endtask

  logic [15:0] hv[30];
  int          ndone;

  initial begin
    vecs[0] = '{16'h1987, 1987, 1'b0};
    vecs[1] = '{16'h0000, 0,    1'b0};
    vecs[2] = '{16'h9999, 9999, 1'b0};
    vecs[3] = '{16'h12A4, 1304, 1'b1};
    vecs[4] = '{16'hFFFF, 281,  1'b1};
    vecs[5] = '{16'h0001, 1,    1'b0};
    vecs[6] = '{16'h5000, 5000, 1'b0};
    vecs[7] = '{16'h0042, 42,   1'b0};

    #2 rst = 1'b1;
    step();
    step();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset bin", 32'(bin_out), 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst = 1'b0;
    step();

    foreach (vecs[i])
      run_conv($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].bin, vecs[i].bad);

    for (int i = 0; i < 20; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      run_conv($sformatf("rnd%0d", i), r, ref_bin(32'(r), D, BW), ref_bad(32'(r), D));
    end

    // start held high: accepts at edges 0,5,10..., results after edges 4,9,14...
    start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      hv[c]  = 16'($urandom);
      bcd_in = hv[c];
      step();
      check($sformatf("hold done c%0d", c), 32'(done), 32'(c % 5 == 4));
      if (c % 5 == 4) begin
        check($sformatf("hold bin c%0d", c), 32'(bin_out), ref_bin(32'(hv[c-4]), D, BW));
        check($sformatf("hold err c%0d", c), 32'(err), 32'(ref_bad(32'(hv[c-4]), D) & CHK));
      end
    end
    start = 1'b0;
    step();
    step();

    // Reset two cycles into a conversion aborts it with no done.
    bcd_in = 16'h4321;
    start  = 1'b1;
    step();
    start  = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort bin", 32'(bin_out), 32'd0);
    check("abort err", 32'(err), 32'd0);
    step();
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (done) ndone++;
    end
    check("abort no done", 32'(ndone), 32'd0);
    run_conv("after reset", 16'h0042, 42, 1'b0);

    run2(8'h59, 59);
    run2(8'h07, 7);
    run2(8'h99, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
